// File: rtl/tiny_dnn_pkg.sv
// Shared types and defaults for the tiny DNN loop sequencer.
package tiny_dnn_pkg;

  localparam int AW_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_WAIT = 3'd4
  } seq_st_t;

endpackage

// File: rtl/tiny_dnn_loop_cnt.sv
// Wrap counter for one loop level: counts 0..max and returns to 0 on inc at max.
// wrap flags "at max" so the next level up can be chained as its carry-in.
module tiny_dnn_loop_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = (cnt_q == max);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tiny_dnn_seq.sv
// Convolution loop sequencer: one ia/wa/oa beat per MAC tap, first beat two cycles
// after a run rise, one beat per cycle while out_ready holds, addresses frozen on stall.
module tiny_dnn_seq
  import tiny_dnn_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESETN,
  input  logic          run,
  input  logic [3:0]    id,
  input  logic [4:0]    iw,
  input  logic [9:0]    is,
  input  logic [3:0]    od,
  input  logic [4:0]    oh,
  input  logic [4:0]    ow,
  input  logic [9:0]    os,
  input  logic [4:0]    kh,
  input  logic [4:0]    kw,
  input  logic [9:0]    fs,
  input  logic [9:0]    ks,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] ia,
  output logic [AW-1:0] wa,
  output logic [AW-1:0] oa,
  output logic          acc_first,
  output logic          acc_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  seq_st_t st_q, st_d;
  logic    run_d_q;

  logic [4:0]    id_q, od_q, oh_q, ow_q, kh_q, kw_q;
  logic [AW-1:0] iw1_q, kw1_q, ow1_q, is_q, os_q, fs_q, ks_q;

  logic [AW-1:0] ia_row_q, ia_pix_q, ia_ch_q, ia_kr_q, ia_q;
  logic [AW-1:0] ia_row_d, ia_pix_d, ia_ch_d, ia_kr_d, ia_d;
  logic [AW-1:0] wa_o_q, wa_ch_q, wa_kr_q, wa_q;
  logic [AW-1:0] wa_o_d, wa_ch_d, wa_kr_d, wa_d;
  logic [AW-1:0] oa_o_q, oa_row_q, oa_q;
  logic [AW-1:0] oa_o_d, oa_row_d, oa_d;
  logic [AW-1:0] nia, nwa, noa;

  logic [4:0] kx_cnt, ky_cnt, c_cnt, x_cnt, y_cnt, o_cnt;
  logic       w_kx, w_ky, w_c, w_x, w_y, w_o;
  logic       adv, ld, last_tap, clr_addr;
  logic       inc_ky, inc_c, inc_x, inc_y, inc_o;
  logic       unused_cnt;

  assign ld        = (st_q == ST_LOAD);
  assign out_valid = (st_q == ST_RUN);
  assign busy      = ld | out_valid;
  assign done      = (st_q == ST_DONE);
  assign adv       = out_valid & out_ready;
  assign last_tap  = w_kx & w_ky & w_c & w_x & w_y & w_o;
  assign clr_addr  = ld | (adv & last_tap);

  assign inc_ky = adv & w_kx;
  assign inc_c  = inc_ky & w_ky;
  assign inc_x  = inc_c & w_c;
  assign inc_y  = inc_x & w_x;
  assign inc_o  = inc_y & w_y;

  assign acc_first = out_valid & (c_cnt == 5'd0) & (ky_cnt == 5'd0) & (kx_cnt == 5'd0);
  assign acc_last  = out_valid & w_c & w_ky & w_kx;

  // Pixel/output-channel indices only steer carries; their values live in the bases.
  assign unused_cnt = ^{x_cnt, y_cnt, o_cnt};

  assign ia = ia_q;
  assign wa = wa_q;
  assign oa = oa_q;

  tiny_dnn_loop_cnt u_kx (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ld), .inc(adv),
                          .max(kw_q), .cnt(kx_cnt), .wrap(w_kx));
  tiny_dnn_loop_cnt u_ky (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ld), .inc(inc_ky),
                          .max(kh_q), .cnt(ky_cnt), .wrap(w_ky));
  tiny_dnn_loop_cnt u_c  (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ld), .inc(inc_c),
                          .max(id_q), .cnt(c_cnt),  .wrap(w_c));
  tiny_dnn_loop_cnt u_x  (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ld), .inc(inc_x),
                          .max(ow_q), .cnt(x_cnt),  .wrap(w_x));
  tiny_dnn_loop_cnt u_y  (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ld), .inc(inc_y),
                          .max(oh_q), .cnt(y_cnt),  .wrap(w_y));
  tiny_dnn_loop_cnt u_o  (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(ld), .inc(inc_o),
                          .max(od_q), .cnt(o_cnt),  .wrap(w_o));

  // Final handshake takes priority over a same-cycle abort.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (run && !run_d_q) st_d = ST_LOAD;
      ST_LOAD: st_d = ST_RUN;
      ST_RUN: begin
        if (adv && last_tap) st_d = ST_DONE;
        else if (!run)       st_d = ST_IDLE;
      end
      ST_DONE: st_d = ST_WAIT;
      ST_WAIT: if (!run) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // Each base holds the address with all inner indices at zero; a carry at level L
  // bumps that level's base by its stride and reloads every base below it.
  always_comb begin
    ia_row_d = ia_row_q; ia_pix_d = ia_pix_q; ia_ch_d = ia_ch_q; ia_kr_d = ia_kr_q; ia_d = ia_q;
    wa_o_d   = wa_o_q;   wa_ch_d  = wa_ch_q;  wa_kr_d = wa_kr_q; wa_d    = wa_q;
    oa_o_d   = oa_o_q;   oa_row_d = oa_row_q; oa_d    = oa_q;
    nia = '0;
    nwa = '0;
    noa = '0;
    if (clr_addr) begin
      ia_row_d = '0; ia_pix_d = '0; ia_ch_d = '0; ia_kr_d = '0; ia_d = '0;
      wa_o_d   = '0; wa_ch_d  = '0; wa_kr_d = '0; wa_d    = '0;
      oa_o_d   = '0; oa_row_d = '0; oa_d    = '0;
    end else if (adv) begin
      if (!w_kx) begin
        ia_d = ia_q + ONE;
        wa_d = wa_q + ONE;
      end else if (!w_ky) begin
        nia = ia_kr_q + iw1_q;
        nwa = wa_kr_q + kw1_q;
        ia_kr_d = nia; ia_d = nia;
        wa_kr_d = nwa; wa_d = nwa;
      end else if (!w_c) begin
        nia = ia_ch_q + is_q;
        nwa = wa_ch_q + fs_q;
        ia_ch_d = nia; ia_kr_d = nia; ia_d = nia;
        wa_ch_d = nwa; wa_kr_d = nwa; wa_d = nwa;
      end else if (!w_x) begin
        nia = ia_pix_q + ONE;
        ia_pix_d = nia; ia_ch_d = nia; ia_kr_d = nia; ia_d = nia;
        wa_ch_d = wa_o_q; wa_kr_d = wa_o_q; wa_d = wa_o_q;
        oa_d = oa_q + ONE;
      end else if (!w_y) begin
        nia = ia_row_q + iw1_q;
        noa = oa_row_q + ow1_q;
        ia_row_d = nia; ia_pix_d = nia; ia_ch_d = nia; ia_kr_d = nia; ia_d = nia;
        wa_ch_d = wa_o_q; wa_kr_d = wa_o_q; wa_d = wa_o_q;
        oa_row_d = noa; oa_d = noa;
      end else begin
        nwa = wa_o_q + ks_q;
        noa = oa_o_q + os_q;
        ia_row_d = '0; ia_pix_d = '0; ia_ch_d = '0; ia_kr_d = '0; ia_d = '0;
        wa_o_d = nwa; wa_ch_d = nwa; wa_kr_d = nwa; wa_d = nwa;
        oa_o_d = noa; oa_row_d = noa; oa_d = noa;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      st_q    <= ST_IDLE;
      run_d_q <= 1'b0;
      id_q  <= '0; od_q  <= '0; oh_q  <= '0; ow_q  <= '0; kh_q <= '0; kw_q <= '0;
      iw1_q <= '0; kw1_q <= '0; ow1_q <= '0;
      is_q  <= '0; os_q  <= '0; fs_q  <= '0; ks_q  <= '0;
    end else begin
      st_q    <= st_d;
      run_d_q <= run;
      if (ld) begin
        id_q  <= {1'b0, id};
        od_q  <= {1'b0, od};
        oh_q  <= oh;
        ow_q  <= ow;
        kh_q  <= kh;
        kw_q  <= kw;
        iw1_q <= AW'(iw) + ONE;
        kw1_q <= AW'(kw) + ONE;
        ow1_q <= AW'(ow) + ONE;
        is_q  <= AW'(is);
        os_q  <= AW'(os);
        fs_q  <= AW'(fs);
        ks_q  <= AW'(ks);
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ia_row_q <= '0; ia_pix_q <= '0; ia_ch_q <= '0; ia_kr_q <= '0; ia_q <= '0;
      wa_o_q   <= '0; wa_ch_q  <= '0; wa_kr_q <= '0; wa_q    <= '0;
      oa_o_q   <= '0; oa_row_q <= '0; oa_q    <= '0;
    end else begin
      ia_row_q <= ia_row_d; ia_pix_q <= ia_pix_d; ia_ch_q <= ia_ch_d; ia_kr_q <= ia_kr_d;
      ia_q     <= ia_d;
      wa_o_q   <= wa_o_d;   wa_ch_q  <= wa_ch_d;  wa_kr_q <= wa_kr_d; wa_q    <= wa_d;
      oa_o_q   <= oa_o_d;   oa_row_q <= oa_row_d; oa_q    <= oa_d;
    end
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Scoreboard bench for tiny_dnn_seq: a direct-formula model queues every expected beat.
module tb_tiny_dnn_seq;

  localparam int AW = 12;

  typedef struct {
    int id, iw, is, od, oh, ow, os, kh, kw, fs, ks;
  } cfg_t;

  typedef struct packed {
    logic [AW-1:0] ia;
    logic [AW-1:0] wa;
    logic [AW-1:0] oa;
    logic          first;
    logic          last;
  } beat_t;

  logic          S_AXI_ACLK = 1'b0;
  logic          S_AXI_ARESETN;
  logic          run;
  logic [3:0]    id;
  logic [4:0]    iw;
  logic [9:0]    is;
  logic [3:0]    od;
  logic [4:0]    oh;
  logic [4:0]    ow;
  logic [9:0]    os;
  logic [4:0]    kh;
  logic [4:0]    kw;
  logic [9:0]    fs;
  logic [9:0]    ks;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] ia, wa, oa;
  logic          acc_first, acc_last, busy, done;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    acc_cnt = 0;
  int    done_cnt = 0;
  bit    done_exp = 1'b0;
  int    rdy_mode = 0;
  int    stall_cnt = 0;

  tiny_dnn_seq #(.AW(AW)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN), .run(run),
    .id(id), .iw(iw), .is(is), .od(od), .oh(oh), .ow(ow), .os(os),
    .kh(kh), .kw(kw), .fs(fs), .ks(ks),
    .out_valid(out_valid), .out_ready(out_ready),
    .ia(ia), .wa(wa), .oa(oa),
    .acc_first(acc_first), .acc_last(acc_last), .busy(busy), .done(done)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_cfg(input cfg_t c);
    id = 4'(c.id); iw = 5'(c.iw); is = 10'(c.is);
    od = 4'(c.od); oh = 5'(c.oh); ow = 5'(c.ow); os = 10'(c.os);
    kh = 5'(c.kh); kw = 5'(c.kw); fs = 10'(c.fs); ks = 10'(c.ks);
  endtask

  task automatic push_exp(input cfg_t c);
    beat_t b;
    for (int o = 0; o <= c.od; o++)
      for (int y = 0; y <= c.oh; y++)
        for (int x = 0; x <= c.ow; x++)
          for (int ch = 0; ch <= c.id; ch++)
            for (int ky = 0; ky <= c.kh; ky++)
              for (int kx = 0; kx <= c.kw; kx++) begin
                b.ia    = AW'(ch * c.is + (y + ky) * (c.iw + 1) + x + kx);
                b.wa    = AW'(o * c.ks + ch * c.fs + ky * (c.kw + 1) + kx);
                b.oa    = AW'(o * c.os + y * (c.ow + 1) + x);
                b.first = (ch == 0) && (ky == 0) && (kx == 0);
                b.last  = (ch == c.id) && (ky == c.kh) && (kx == c.kw);
                sb_q.push_back(b);
              end
  endtask

  // Drives out_ready: always high, or random with a forced 3-cycle stall.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge S_AXI_ACLK);
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
        stall_cnt = 0;
      end else begin
        stall_cnt++;
        if (stall_cnt >= 4 && stall_cnt < 7) out_ready = 1'b0;
        else out_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Sampled just before each rising edge; a presented beat must match the queue head.
  always @(negedge S_AXI_ACLK) begin
    beat_t e;
    #4;
    if (done) done_cnt++;
    if (done_exp) begin
      chk("done_after_last", done, 1);
      chk("busy_in_done", busy, 0);
      done_exp = 1'b0;
    end
    if (S_AXI_ARESETN && out_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_vld", out_valid, 0);
      end else begin
        e = sb_q[0];
        chk("ia", ia, e.ia);
        chk("wa", wa, e.wa);
        chk("oa", oa, e.oa);
        chk("acc_first", acc_first, e.first);
        chk("acc_last", acc_last, e.last);
        if (out_ready) begin
          void'(sb_q.pop_front());
          acc_cnt++;
          if (sb_q.size() == 0) done_exp = 1'b1;
        end
      end
    end
  end

  task automatic start_run(input cfg_t c);
    set_cfg(c);
    push_exp(c);
    @(negedge S_AXI_ACLK);
    run = 1'b1;
    @(negedge S_AXI_ACLK);
    chk("load_busy", busy, 1);
    chk("load_vld", out_valid, 0);
    @(negedge S_AXI_ACLK);
    chk("first_vld", out_valid, 1);
  endtask

  task automatic run_job(input cfg_t c, input bit scramble);
    int d0;
    bit ok;
    d0 = done_cnt;
    start_run(c);
    if (scramble) begin
      id = 4'($urandom); iw = 5'($urandom); is = 10'($urandom); od = 4'($urandom);
      kw = 5'($urandom); fs = 10'($urandom); ks = 10'($urandom); os = 10'($urandom);
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge S_AXI_ACLK);
    end
    if (!ok) begin
      chk("beats_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    repeat (4) @(negedge S_AXI_ACLK);
    chk("done_count", done_cnt - d0, 1);
    chk("wait_busy", busy, 0);
    chk("wait_no_vld", out_valid, 0);
    run = 1'b0;
    repeat (2) @(negedge S_AXI_ACLK);
  endtask

  task automatic wait_accepts(input int n);
    int a0;
    a0 = acc_cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge S_AXI_ACLK);
      if (acc_cnt - a0 >= n) break;
    end
    chk("accept_count", (acc_cnt - a0 >= n) ? 1 : 0, 1);
  endtask

  initial begin
    cfg_t c0, c2, c3, c6;
    int   d0;
    c0 = '{id:0, iw:0, is:0, od:0, oh:0, ow:0, os:0, kh:0, kw:0, fs:0, ks:0};
    c2 = '{id:0, iw:2, is:0, od:0, oh:1, ow:1, os:0, kh:1, kw:1, fs:0, ks:0};
    c3 = '{id:1, iw:0, is:100, od:1, oh:0, ow:0, os:20, kh:0, kw:0, fs:4, ks:50};
    c6 = '{id:7, iw:0, is:1023, od:0, oh:0, ow:0, os:0, kh:0, kw:0, fs:0, ks:0};

    S_AXI_ARESETN = 1'b0;
    run = 1'b0;
    set_cfg(c0);
    repeat (3) @(negedge S_AXI_ACLK);
    chk("rst_vld", out_valid, 0);
    chk("rst_ia", ia, 0);
    chk("rst_wa", wa, 0);
    chk("rst_oa", oa, 0);
    chk("rst_first", acc_first, 0);
    chk("rst_last", acc_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    S_AXI_ARESETN = 1'b1;
    repeat (2) @(negedge S_AXI_ACLK);

    run_job(c0, 1'b0);
    run_job(c2, 1'b0);
    run_job(c3, 1'b0);

    rdy_mode = 1;
    run_job(c2, 1'b1);
    rdy_mode = 0;

    // Abort after 5 accepted beats, then a clean restart.
    d0 = done_cnt;
    start_run(c2);
    wait_accepts(5);
    run = 1'b0;
    @(negedge S_AXI_ACLK);
    chk("abort_vld", out_valid, 0);
    sb_q.delete();
    repeat (4) @(negedge S_AXI_ACLK);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_busy", busy, 0);
    run_job(c2, 1'b0);

    run_job(c6, 1'b0);

    // Reset in the middle of a run.
    d0 = done_cnt;
    start_run(c2);
    wait_accepts(3);
    S_AXI_ARESETN = 1'b0;
    #1;
    chk("midrst_vld", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ia", ia, 0);
    sb_q.delete();
    run = 1'b0;
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    repeat (4) @(negedge S_AXI_ACLK);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_job(c3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
